// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the CPU datapath.
// The controller is the master: it observes the opcode, memory ack and ALU
// zero flag, and drives every datapath enable and select.
interface multicycle_ctrl_if;
  logic [5:0] ct_inst;
  logic       mem_ack;
  logic       alu_zero;
  logic       ct_mem_req;
  logic       ct_mem_wen;
  logic       ct_iord;
  logic       ct_ir_wen;
  logic       ct_pc_wen;
  logic [1:0] ct_pc_src;
  logic       ct_alu_srca;
  logic [1:0] ct_alu_srcb;
  logic [1:0] ct_alu_op;
  logic       ct_rf_wen;
  logic       ct_rf_dst;
  logic       ct_data_rf;
  logic       ct_branch;
  logic       ct_branchn;
  logic       ct_illegal;
  logic       ct_mem_err;
  logic       ct_retire;

  modport master (
    input  ct_inst, mem_ack, alu_zero,
    output ct_mem_req, ct_mem_wen, ct_iord, ct_ir_wen, ct_pc_wen, ct_pc_src,
           ct_alu_srca, ct_alu_srcb, ct_alu_op, ct_rf_wen, ct_rf_dst,
           ct_data_rf, ct_branch, ct_branchn, ct_illegal, ct_mem_err, ct_retire
  );

  modport slave (
    output ct_inst, mem_ack, alu_zero,
    input  ct_mem_req, ct_mem_wen, ct_iord, ct_ir_wen, ct_pc_wen, ct_pc_src,
           ct_alu_srca, ct_alu_srcb, ct_alu_op, ct_rf_wen, ct_rf_dst,
           ct_data_rf, ct_branch, ct_branchn, ct_illegal, ct_mem_err, ct_retire
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control sequencer.
// Steps R-type, lw, sw, beq, bne, j, addiu and slti through fetch, decode,
// execute, memory and writeback, waiting on a shared memory through req/ack
// with a bounded wait. Undefined opcodes either trap or retire as a NOP.
module multicycle_ctrl #(
  parameter int WAIT_W       = 8,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MA  = 4'd2,
    S_MR  = 4'd3,
    S_MWB = 4'd4,
    S_MW  = 4'd5,
    S_EX  = 4'd6,
    S_RWB = 4'd7,
    S_BR  = 4'd8,
    S_J   = 4'd9,
    S_IX  = 4'd10,
    S_IWB = 4'd11,
    S_ILL = 4'd12
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // The wait that would bring the count to 2**WAIT_W-1 is the timeout cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = {{(WAIT_W-1){1'b1}}, 1'b0};

  state_t            state, state_d;
  logic [5:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  logic              req_state;
  logic              ack_ok;
  logic              timeout;

  logic       mem_req, mem_wen, iord, ir_wen, pc_wen;
  logic [1:0] pc_src;
  logic       alu_srca;
  logic [1:0] alu_srcb;
  logic [1:0] alu_op;
  logic       rf_wen, rf_dst, data_rf, branch, branchn;
  logic       illegal, mem_err, retire;

  assign req_state = (state == S_IF) || (state == S_MR) || (state == S_MW);
  assign ack_ok    = req_state && bus.mem_ack;
  assign timeout   = req_state && !bus.mem_ack && (wait_cnt == WAIT_LAST);

  // State, latched opcode and memory-wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IF;
      op_q     <= 6'd0;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
      if (state == S_ID) op_q <= bus.ct_inst;
    end
  end

  // Next state and wait count; the count only survives a stalled request cycle.
  always_comb begin
    state_d = S_IF;
    wait_d  = '0;
    if (req_state && !ack_ok && !timeout) wait_d = wait_cnt + 1'b1;
    case (state)
      S_IF:  state_d = ack_ok ? S_ID : S_IF;
      S_ID: begin
        case (bus.ct_inst)
          OP_R:             state_d = S_EX;
          OP_LW, OP_SW:     state_d = S_MA;
          OP_BEQ, OP_BNE:   state_d = S_BR;
          OP_J:             state_d = S_J;
          OP_ADDIU, OP_SLTI: state_d = S_IX;
          default:          state_d = ILLEGAL_TRAP ? S_ILL : S_IF;
        endcase
      end
      S_MA: begin
        if (op_q == OP_LW)      state_d = S_MR;
        else if (op_q == OP_SW) state_d = S_MW;
        else                    state_d = S_IF;
      end
      S_MR: begin
        if (ack_ok)       state_d = S_MWB;
        else if (timeout) state_d = S_IF;
        else              state_d = S_MR;
      end
      S_MWB: state_d = S_IF;
      S_MW:  state_d = (ack_ok || timeout) ? S_IF : S_MW;
      S_EX:  state_d = S_RWB;
      S_RWB: state_d = S_IF;
      S_BR:  state_d = S_IF;
      S_J:   state_d = S_IF;
      S_IX:  state_d = S_IWB;
      S_IWB: state_d = S_IF;
      S_ILL: state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // Per-state datapath controls, all held low while reset is asserted.
  always_comb begin
    mem_req  = 1'b0;
    mem_wen  = 1'b0;
    iord     = 1'b0;
    ir_wen   = 1'b0;
    pc_wen   = 1'b0;
    pc_src   = 2'b00;
    alu_srca = 1'b0;
    alu_srcb = 2'b00;
    alu_op   = 2'b00;
    rf_wen   = 1'b0;
    rf_dst   = 1'b0;
    data_rf  = 1'b0;
    branch   = 1'b0;
    branchn  = 1'b0;
    illegal  = 1'b0;
    mem_err  = 1'b0;
    retire   = 1'b0;
    if (rst) begin
      case (state)
        S_IF: begin
          mem_req  = 1'b1;
          alu_srcb = 2'b01;
          if (ack_ok) begin
            ir_wen = 1'b1;
            pc_wen = 1'b1;
          end else if (timeout) begin
            mem_err = 1'b1;
            retire  = 1'b1;
          end
        end
        S_ID: begin
          alu_srcb = 2'b11;
          case (bus.ct_inst)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDIU, OP_SLTI: retire = 1'b0;
            default: retire = !ILLEGAL_TRAP;
          endcase
        end
        S_MA: begin
          alu_srca = 1'b1;
          alu_srcb = 2'b10;
        end
        S_MR: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (!ack_ok && timeout) begin
            mem_err = 1'b1;
            retire  = 1'b1;
          end
        end
        S_MWB: begin
          rf_wen  = 1'b1;
          data_rf = 1'b1;
          retire  = 1'b1;
        end
        S_MW: begin
          mem_req = 1'b1;
          mem_wen = 1'b1;
          iord    = 1'b1;
          if (ack_ok) begin
            retire = 1'b1;
          end else if (timeout) begin
            mem_err = 1'b1;
            retire  = 1'b1;
          end
        end
        S_EX: begin
          alu_srca = 1'b1;
          alu_op   = 2'b10;
        end
        S_RWB: begin
          rf_wen = 1'b1;
          rf_dst = 1'b1;
          retire = 1'b1;
        end
        S_BR: begin
          alu_srca = 1'b1;
          alu_op   = 2'b01;
          pc_src   = 2'b01;
          branch   = (op_q == OP_BEQ);
          branchn  = (op_q == OP_BNE);
          pc_wen   = (op_q == OP_BEQ) ? bus.alu_zero : !bus.alu_zero;
          retire   = 1'b1;
        end
        S_J: begin
          pc_src = 2'b10;
          pc_wen = 1'b1;
          retire = 1'b1;
        end
        S_IX: begin
          alu_srca = 1'b1;
          alu_srcb = 2'b10;
          alu_op   = (op_q == OP_ADDIU) ? 2'b00 : 2'b11;
        end
        S_IWB: begin
          rf_wen = 1'b1;
          retire = 1'b1;
        end
        S_ILL: begin
          illegal = 1'b1;
          retire  = 1'b1;
        end
        default: retire = 1'b0;
      endcase
    end
  end

  assign bus.ct_mem_req  = mem_req;
  assign bus.ct_mem_wen  = mem_wen;
  assign bus.ct_iord     = iord;
  assign bus.ct_ir_wen   = ir_wen;
  assign bus.ct_pc_wen   = pc_wen;
  assign bus.ct_pc_src   = pc_src;
  assign bus.ct_alu_srca = alu_srca;
  assign bus.ct_alu_srcb = alu_srcb;
  assign bus.ct_alu_op   = alu_op;
  assign bus.ct_rf_wen   = rf_wen;
  assign bus.ct_rf_dst   = rf_dst;
  assign bus.ct_data_rf  = data_rf;
  assign bus.ct_branch   = branch;
  assign bus.ct_branchn  = branchn;
  assign bus.ct_illegal  = illegal;
  assign bus.ct_mem_err  = mem_err;
  assign bus.ct_retire   = retire;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one instance with the default wait
// width and trapping, one with a 2-bit wait counter and NOP-on-undefined.
module tb_multicycle_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  multicycle_ctrl_if bus_a ();
  multicycle_ctrl_if bus_b ();

  multicycle_ctrl #(.WAIT_W(8), .ILLEGAL_TRAP(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.master)
  );

  multicycle_ctrl #(.WAIT_W(2), .ILLEGAL_TRAP(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.master)
  );

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  // Field order: req wen iord irw pcw pcsrc srca srcb aluop rfw dst drf br brn ill err ret
  localparam logic [19:0] E_ZERO    = 20'b0_0_0_0_0_00_0_00_00_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_IF      = 20'b1_0_0_0_0_00_0_01_00_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_IF_ACK  = 20'b1_0_0_1_1_00_0_01_00_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_IF_TO   = 20'b1_0_0_0_0_00_0_01_00_0_0_0_0_0_0_1_1;
  localparam logic [19:0] E_ID      = 20'b0_0_0_0_0_00_0_11_00_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_ID_NOP  = 20'b0_0_0_0_0_00_0_11_00_0_0_0_0_0_0_0_1;
  localparam logic [19:0] E_MA      = 20'b0_0_0_0_0_00_1_10_00_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_MR      = 20'b1_0_1_0_0_00_0_00_00_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_MWB     = 20'b0_0_0_0_0_00_0_00_00_1_0_1_0_0_0_0_1;
  localparam logic [19:0] E_MW      = 20'b1_1_1_0_0_00_0_00_00_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_MW_ACK  = 20'b1_1_1_0_0_00_0_00_00_0_0_0_0_0_0_0_1;
  localparam logic [19:0] E_EX      = 20'b0_0_0_0_0_00_1_00_10_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_RWB     = 20'b0_0_0_0_0_00_0_00_00_1_1_0_0_0_0_0_1;
  localparam logic [19:0] E_BEQ_TK  = 20'b0_0_0_0_1_01_1_00_01_0_0_0_1_0_0_0_1;
  localparam logic [19:0] E_BNE_NT  = 20'b0_0_0_0_0_01_1_00_01_0_0_0_0_1_0_0_1;
  localparam logic [19:0] E_J       = 20'b0_0_0_0_1_10_0_00_00_0_0_0_0_0_0_0_1;
  localparam logic [19:0] E_IX_ADD  = 20'b0_0_0_0_0_00_1_10_00_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_IX_SLT  = 20'b0_0_0_0_0_00_1_10_11_0_0_0_0_0_0_0_0;
  localparam logic [19:0] E_IWB     = 20'b0_0_0_0_0_00_0_00_00_1_0_0_0_0_0_0_1;
  localparam logic [19:0] E_ILL     = 20'b0_0_0_0_0_00_0_00_00_0_0_0_0_0_1_0_1;

  logic [19:0] obs_a;
  logic [19:0] obs_b;

  assign obs_a = {bus_a.ct_mem_req, bus_a.ct_mem_wen, bus_a.ct_iord, bus_a.ct_ir_wen,
                  bus_a.ct_pc_wen, bus_a.ct_pc_src, bus_a.ct_alu_srca, bus_a.ct_alu_srcb,
                  bus_a.ct_alu_op, bus_a.ct_rf_wen, bus_a.ct_rf_dst, bus_a.ct_data_rf,
                  bus_a.ct_branch, bus_a.ct_branchn, bus_a.ct_illegal, bus_a.ct_mem_err,
                  bus_a.ct_retire};
  assign obs_b = {bus_b.ct_mem_req, bus_b.ct_mem_wen, bus_b.ct_iord, bus_b.ct_ir_wen,
                  bus_b.ct_pc_wen, bus_b.ct_pc_src, bus_b.ct_alu_srca, bus_b.ct_alu_srcb,
                  bus_b.ct_alu_op, bus_b.ct_rf_wen, bus_b.ct_rf_dst, bus_b.ct_data_rf,
                  bus_b.ct_branch, bus_b.ct_branchn, bus_b.ct_illegal, bus_b.ct_mem_err,
                  bus_b.ct_retire};

  // Free-running clock, rising edge active.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [19:0] got, input logic [19:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", tag, got, want);
    end
  endtask

  // Drive instance A inputs just after the falling edge, then let outputs settle.
  task automatic applyStimulus(input logic [5:0] inst, input logic ack, input logic zero);
    @(negedge clk);
    bus_a.ct_inst  = inst;
    bus_a.mem_ack  = ack;
    bus_a.alu_zero = zero;
    #1;
  endtask

  task automatic stepA(input string tag, input logic [5:0] inst, input logic ack,
                       input logic zero, input logic [19:0] want);
    applyStimulus(inst, ack, zero);
    checkOutput(tag, obs_a, want);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus_a.ct_inst = 6'd0; bus_a.mem_ack = 1'b0; bus_a.alu_zero = 1'b0;
    bus_b.ct_inst = 6'd0; bus_b.mem_ack = 1'b0; bus_b.alu_zero = 1'b0;

    @(negedge clk); #1;
    checkOutput("rst_a", obs_a, E_ZERO);
    checkOutput("rst_b", obs_b, E_ZERO);

    // Release reset; B never gets an ack so it times out on its third cycle.
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("a_if_after_rst", obs_a, E_IF);
    checkOutput("b_if_wait1", obs_b, E_IF);
    @(negedge clk); #1;
    checkOutput("b_if_wait2", obs_b, E_IF);
    @(negedge clk); #1;
    checkOutput("b_if_timeout", obs_b, E_IF_TO);
    @(negedge clk);
    bus_b.ct_inst = OP_BAD;
    bus_b.mem_ack = 1'b1;
    #1;
    checkOutput("b_if_ack", obs_b, E_IF_ACK);
    @(negedge clk);
    bus_b.mem_ack = 1'b0;
    #1;
    checkOutput("b_id_nop", obs_b, E_ID_NOP);
    @(negedge clk); #1;
    checkOutput("b_back_if", obs_b, E_IF);

    // lw with immediate acks: five cycles, writeback from MDR in the last.
    stepA("lw_if",  OP_LW, 1'b1, 1'b0, E_IF_ACK);
    stepA("lw_id",  OP_LW, 1'b0, 1'b0, E_ID);
    stepA("lw_ma",  OP_LW, 1'b0, 1'b0, E_MA);
    stepA("lw_mr",  OP_LW, 1'b1, 1'b0, E_MR);
    stepA("lw_mwb", OP_LW, 1'b0, 1'b0, E_MWB);

    // R-type.
    stepA("r_if",  OP_R, 1'b1, 1'b0, E_IF_ACK);
    stepA("r_id",  OP_R, 1'b0, 1'b0, E_ID);
    stepA("r_ex",  OP_R, 1'b0, 1'b0, E_EX);
    stepA("r_rwb", OP_R, 1'b0, 1'b0, E_RWB);

    // beq taken and bne not taken, both with alu_zero=1.
    stepA("beq_if", OP_BEQ, 1'b1, 1'b1, E_IF_ACK);
    stepA("beq_id", OP_BEQ, 1'b0, 1'b1, E_ID);
    stepA("beq_br", OP_BEQ, 1'b0, 1'b1, E_BEQ_TK);
    stepA("bne_if", OP_BNE, 1'b1, 1'b1, E_IF_ACK);
    stepA("bne_id", OP_BNE, 1'b0, 1'b1, E_ID);
    stepA("bne_br", OP_BNE, 1'b0, 1'b1, E_BNE_NT);

    // sw acked after three wait cycles: write enable held four cycles.
    stepA("sw_if",  OP_SW, 1'b1, 1'b0, E_IF_ACK);
    stepA("sw_id",  OP_SW, 1'b0, 1'b0, E_ID);
    stepA("sw_ma",  OP_SW, 1'b0, 1'b0, E_MA);
    stepA("sw_mw1", OP_SW, 1'b0, 1'b0, E_MW);
    stepA("sw_mw2", OP_SW, 1'b0, 1'b0, E_MW);
    stepA("sw_mw3", OP_SW, 1'b0, 1'b0, E_MW);
    stepA("sw_mw4", OP_SW, 1'b1, 1'b0, E_MW_ACK);
    stepA("sw_next_if", OP_SW, 1'b0, 1'b0, E_IF);

    // slti selects slt on the ALU; addiu selects add.
    stepA("slti_if",  OP_SLTI, 1'b1, 1'b0, E_IF_ACK);
    stepA("slti_id",  OP_SLTI, 1'b0, 1'b0, E_ID);
    stepA("slti_ix",  OP_SLTI, 1'b0, 1'b0, E_IX_SLT);
    stepA("slti_iwb", OP_SLTI, 1'b0, 1'b0, E_IWB);
    stepA("addiu_if", OP_ADDIU, 1'b1, 1'b0, E_IF_ACK);
    stepA("addiu_id", OP_ADDIU, 1'b0, 1'b0, E_ID);
    stepA("addiu_ix", OP_ADDIU, 1'b0, 1'b0, E_IX_ADD);
    stepA("addiu_iwb", OP_ADDIU, 1'b0, 1'b0, E_IWB);

    // Jump.
    stepA("j_if", OP_J, 1'b1, 1'b0, E_IF_ACK);
    stepA("j_id", OP_J, 1'b0, 1'b0, E_ID);
    stepA("j_j",  OP_J, 1'b0, 1'b0, E_J);

    // Undefined opcode traps in the third cycle.
    stepA("ill_if",  OP_BAD, 1'b1, 1'b0, E_IF_ACK);
    stepA("ill_id",  OP_BAD, 1'b0, 1'b0, E_ID);
    stepA("ill_ill", OP_BAD, 1'b0, 1'b0, E_ILL);

    // Reset asserted while lw waits in S_MR aborts the instruction.
    stepA("rlw_if", OP_LW, 1'b1, 1'b0, E_IF_ACK);
    stepA("rlw_id", OP_LW, 1'b0, 1'b0, E_ID);
    stepA("rlw_ma", OP_LW, 1'b0, 1'b0, E_MA);
    stepA("rlw_mr", OP_LW, 1'b0, 1'b0, E_MR);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_mr", obs_a, E_ZERO);
    @(negedge clk); #1;
    checkOutput("rst_mid_mr_hold", obs_a, E_ZERO);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("after_rst_if", obs_a, E_IF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
